sprite_bank_control: RTL and testbench

Parametrised multi-sprite motion engine that generalises the single bouncing-enemy controller to `NUM_SPRITES` independent sprites. All sprites share one rate divider, carry a per-sprite velocity and direction, and bounce off the screen edges. The block adds four things the single controller lacked: a runtime load/kill interface, edge-clamped loading, per-sprite bounce event pulses, and registered sprite-vs-player collision flags. It sits between the game FSM, which spawns and kills sprites, and the draw/erase datapath, which consumes positions and the step pulse.

---
 rtl/sprite_bank_control_pkg.sv | 9 +
 rtl/sprite_axis.sv | 58 +++++
 rtl/sprite_bank_control.sv | 89 ++++++++
 tb/tb_sprite_bank_control.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_bank_control_pkg.sv
// sprite_bank_control_pkg: shared screen geometry and direction encoding for sprite, player and draw blocks
package sprite_bank_control_pkg;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int SPR_SIZE = 4;
  localparam int PLR_SIZE = 4;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BACK = 1'b1;
endpackage

// File: rtl/sprite_axis.sv
// sprite_axis: one-axis position/direction/step register with edge clamp and bounce detect
module sprite_axis import sprite_bank_control_pkg::*; #(
  parameter int W = 8,
  parameter int DW = 3,
  parameter int LIMIT = 156
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [W-1:0]  load_pos_i,
  input  logic [DW-1:0] load_d_i,
  input  logic          load_dir_i,
  output logic [W-1:0]  pos_o,
  output logic          bnc_o
);
  localparam logic [W:0] LIM = (W+1)'(LIMIT);
  logic [W-1:0] pos_q, pos_d;
  logic [DW-1:0] d_q, d_d;
  logic dir_q, dir_d;
  logic [W:0] p, dd, sum, diff, nxt;
  logic lo, hi;
  assign p = {1'b0, pos_q};
  assign dd = (W+1)'(d_q);
  assign sum = p + dd;
  assign diff = p - dd;
  assign lo = (dir_q == DIR_BACK) && (p <= dd);
  assign hi = (dir_q == DIR_FWD) && (sum >= LIM);
  assign bnc_o = (d_q != '0) && (lo || hi);
  assign nxt = lo ? '0 : hi ? LIM : (dir_q == DIR_BACK) ? diff : sum;
  assign pos_o = pos_q;
  // next state: load (clamped) beats step; a zero step holds the axis
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    d_d = d_q;
    if (load_i) begin
      pos_d = ({1'b0, load_pos_i} >= LIM) ? LIM[W-1:0] : load_pos_i;
      dir_d = load_dir_i;
      d_d = load_d_i;
    end else if (step_i && d_q != '0) begin
      pos_d = nxt[W-1:0];
      dir_d = (lo || hi) ? ~dir_q : dir_q;
    end
  end
  // state registers, reset to origin moving forward with zero step
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pos_q <= '0;
      dir_q <= DIR_FWD;
      d_q <= '0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      d_q <= d_d;
    end
  end
endmodule

// File: rtl/sprite_bank_control.sv
// sprite_bank_control: multi-sprite motion engine with shared rate divider, load/kill, bounce pulses and player collision
module sprite_bank_control import sprite_bank_control_pkg::*; #(
  parameter int NUM_SPRITES = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int D_W = 3,
  parameter int SCREEN_W = SCR_W,
  parameter int SCREEN_H = SCR_H,
  parameter int SIZE = SPR_SIZE,
  parameter int PLAYER_SIZE = PLR_SIZE,
  parameter int RATE_DIV = 249999
) (
  input  logic                                                clk,
  input  logic                                                resetn,
  input  logic                                                play,
  input  logic                                                load_valid,
  input  logic [(NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1)-1:0] load_id,
  input  logic [X_W-1:0]                                      load_x,
  input  logic [Y_W-1:0]                                      load_y,
  input  logic [D_W-1:0]                                      load_dx,
  input  logic [D_W-1:0]                                      load_dy,
  input  logic                                                load_left,
  input  logic                                                load_up,
  input  logic [NUM_SPRITES-1:0]                              kill,
  input  logic [X_W-1:0]                                      player_x,
  input  logic [Y_W-1:0]                                      player_y,
  output logic [NUM_SPRITES*X_W-1:0]                          pos_x,
  output logic [NUM_SPRITES*Y_W-1:0]                          pos_y,
  output logic [NUM_SPRITES-1:0]                              active,
  output logic                                                step,
  output logic [NUM_SPRITES-1:0]                              bounce,
  output logic [NUM_SPRITES-1:0]                              hit
);
  localparam int CW = RATE_DIV > 0 ? $clog2(RATE_DIV + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick, step_q;
  logic [NUM_SPRITES-1:0] active_q, active_d, bounce_q, bounce_d, hit_q, hit_d;
  logic [NUM_SPRITES-1:0] ld, mv, bx, by;
  logic [X_W:0] px_lo, px_hi;
  logic [Y_W:0] py_lo, py_hi;
  assign tick = play && (cnt_q == CW'(RATE_DIV));
  assign cnt_d = !play ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  assign mv = {NUM_SPRITES{tick}} & active_q & ~ld;
  assign active_d = (active_q & ~kill) | ld;
  assign bounce_d = mv & (bx | by);
  assign px_lo = {1'b0, player_x};
  assign px_hi = px_lo + (X_W+1)'(PLAYER_SIZE);
  assign py_lo = {1'b0, player_y};
  assign py_hi = py_lo + (Y_W+1)'(PLAYER_SIZE);
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    assign ld[i] = load_valid && (int'(load_id) == i);
    assign sx = {1'b0, pos_x[i*X_W +: X_W]};
    assign sy = {1'b0, pos_y[i*Y_W +: Y_W]};
    assign hit_d[i] = active_q[i] && (sx < px_hi) && (px_lo < sx + (X_W+1)'(SIZE))
                      && (sy < py_hi) && (py_lo < sy + (Y_W+1)'(SIZE));
    sprite_axis #(.W(X_W), .DW(D_W), .LIMIT(SCREEN_W - SIZE)) u_x (
      .clk(clk), .resetn(resetn), .load_i(ld[i]), .step_i(mv[i]),
      .load_pos_i(load_x), .load_d_i(load_dx), .load_dir_i(load_left),
      .pos_o(pos_x[i*X_W +: X_W]), .bnc_o(bx[i])
    );
    sprite_axis #(.W(Y_W), .DW(D_W), .LIMIT(SCREEN_H - SIZE)) u_y (
      .clk(clk), .resetn(resetn), .load_i(ld[i]), .step_i(mv[i]),
      .load_pos_i(load_y), .load_d_i(load_dy), .load_dir_i(load_up),
      .pos_o(pos_y[i*Y_W +: Y_W]), .bnc_o(by[i])
    );
  end
  // divider, live mask, step/bounce pulses and collision flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      step_q <= 1'b0;
      active_q <= '0;
      bounce_q <= '0;
      hit_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      step_q <= tick;
      active_q <= active_d;
      bounce_q <= bounce_d;
      hit_q <= hit_d;
    end
  end
  assign step = step_q;
  assign active = active_q;
  assign bounce = bounce_q;
  assign hit = hit_q;
endmodule

// File: tb/tb_sprite_bank_control.sv
// tb_sprite_bank_control: directed scenarios plus randomized traffic against a behavioural sprite model
module tb_sprite_bank_control;
  localparam int N = 3;
  localparam int RD = 3;
  localparam int XL = 156;
  localparam int YL = 116;
  logic clk = 0;
  logic resetn, play, load_valid, load_left, load_up;
  logic [1:0] load_id;
  logic [7:0] load_x, player_x;
  logic [6:0] load_y, player_y;
  logic [2:0] load_dx, load_dy;
  logic [N-1:0] kill, active, bounce, hit;
  logic [N*8-1:0] pos_x;
  logic [N*7-1:0] pos_y;
  logic step;
  int n_chk = 0, n_pass = 0;
  int mx[N], my[N], mdx[N], mdy[N], mcnt;
  bit ml[N], mu[N], ma[N], mb[N], mh[N], ms;

  sprite_bank_control #(.NUM_SPRITES(N), .RATE_DIV(RD)) dut (
    .clk(clk), .resetn(resetn), .play(play), .load_valid(load_valid), .load_id(load_id),
    .load_x(load_x), .load_y(load_y), .load_dx(load_dx), .load_dy(load_dy),
    .load_left(load_left), .load_up(load_up), .kill(kill), .player_x(player_x),
    .player_y(player_y), .pos_x(pos_x), .pos_y(pos_y), .active(active), .step(step),
    .bounce(bounce), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic void ax(inout int p, inout bit dir, input int d, input int lim, output bit b);
    b = 0;
    if (d == 0) return;
    if (dir) begin
      if (p <= d) begin p = 0; dir = 0; b = 1; end
      else p = p - d;
    end else begin
      if (p + d >= lim) begin p = lim; dir = 1; b = 1; end
      else p = p + d;
    end
  endfunction

  task automatic model();
    bit t, bxx, byy;
    bit nh[N];
    int p;
    bit dr;
    if (!resetn) begin
      mcnt = 0; ms = 0;
      for (int i = 0; i < N; i++) begin
        mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0;
        ml[i] = 0; mu[i] = 0; ma[i] = 0; mb[i] = 0; mh[i] = 0;
      end
      return;
    end
    for (int i = 0; i < N; i++)
      nh[i] = ma[i] && mx[i] < player_x + 4 && player_x < mx[i] + 4 && my[i] < player_y + 4 && player_y < my[i] + 4;
    t = play && mcnt == RD;
    if (play) mcnt = t ? 0 : mcnt + 1;
    for (int i = 0; i < N; i++) begin
      mb[i] = 0;
      if (load_valid && load_id == i) begin
        mx[i] = load_x > XL ? XL : load_x;
        my[i] = load_y > YL ? YL : load_y;
        mdx[i] = load_dx; mdy[i] = load_dy;
        ml[i] = load_left; mu[i] = load_up; ma[i] = 1;
      end else begin
        if (t && ma[i]) begin
          p = mx[i]; dr = ml[i]; ax(p, dr, mdx[i], XL, bxx); mx[i] = p; ml[i] = dr;
          p = my[i]; dr = mu[i]; ax(p, dr, mdy[i], YL, byy); my[i] = p; mu[i] = dr;
          mb[i] = bxx | byy;
        end
        if (kill[i]) ma[i] = 0;
      end
      mh[i] = nh[i];
    end
    ms = t;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    check("step", int'(step), int'(ms));
    for (int i = 0; i < N; i++) begin
      check($sformatf("x%0d", i), int'(pos_x[i*8 +: 8]), mx[i]);
      check($sformatf("y%0d", i), int'(pos_y[i*7 +: 7]), my[i]);
      check($sformatf("act%0d", i), int'(active[i]), int'(ma[i]));
      check($sformatf("bnc%0d", i), int'(bounce[i]), int'(mb[i]));
      check($sformatf("hit%0d", i), int'(hit[i]), int'(mh[i]));
    end
  endtask

  task automatic ld(int id, int x, int y, int dx, int dy, bit l, bit u);
    load_valid = 1; load_id = 2'(id); load_x = 8'(x); load_y = 7'(y);
    load_dx = 3'(dx); load_dy = 3'(dy); load_left = l; load_up = u;
    cyc();
    load_valid = 0;
  endtask

  task automatic wait_step();
    int k = 0;
    do begin cyc(); k++; end while (!step && k < 20);
    if (!step) check("step_timeout", 0, 1);
  endtask

  initial begin
    int ns;
    resetn = 0; play = 1; load_valid = 0; load_id = 0; load_x = 0; load_y = 0;
    load_dx = 0; load_dy = 0; load_left = 0; load_up = 0; kill = 0;
    player_x = 200; player_y = 100;
    repeat (3) cyc();
    check("rst_posx", int'(pos_x), 0);
    check("rst_act", int'(active), 0);
    resetn = 1;
    ns = 0;
    for (int k = 0; k < 12; k++) begin cyc(); ns += int'(step); end
    check("rate", ns, 3);
    check("idle_act", int'(active), 0);
    ld(1, 10, 20, 2, 1, 0, 0);
    check("ld_x", int'(pos_x[8 +: 8]), 10);
    check("ld_y", int'(pos_y[7 +: 7]), 20);
    wait_step();
    check("st_x", int'(pos_x[8 +: 8]), 12);
    check("st_y", int'(pos_y[7 +: 7]), 21);
    ld(2, 154, 10, 3, 0, 0, 0);
    wait_step();
    check("redge_x", int'(pos_x[16 +: 8]), 156);
    check("redge_b", int'(bounce[2]), 1);
    wait_step();
    check("redge_x2", int'(pos_x[16 +: 8]), 153);
    check("redge_b2", int'(bounce[2]), 0);
    ld(0, 2, 1, 3, 2, 1, 1);
    wait_step();
    check("corner_x", int'(pos_x[0 +: 8]), 0);
    check("corner_y", int'(pos_y[0 +: 7]), 0);
    check("corner_b", int'(bounce[0]), 1);
    wait_step();
    check("corner_b2", int'(bounce[0]), 0);
    check("corner_x2", int'(pos_x[0 +: 8]), 3);
    check("corner_y2", int'(pos_y[0 +: 7]), 2);
    for (int k = 0; k < 8 && mcnt != RD; k++) cyc();
    kill = 3'b001;
    ld(0, 50, 50, 1, 1, 0, 0);
    kill = 0;
    check("sim_step", int'(step), 1);
    check("sim_x", int'(pos_x[0 +: 8]), 50);
    check("sim_y", int'(pos_y[0 +: 7]), 50);
    check("sim_b", int'(bounce[0]), 0);
    check("sim_act", int'(active[0]), 1);
    ld(0, 200, 127, 0, 0, 0, 0);
    check("clamp_x", int'(pos_x[0 +: 8]), 156);
    check("clamp_y", int'(pos_y[0 +: 7]), 116);
    ld(3, 20, 20, 1, 1, 0, 0);
    player_x = 50; player_y = 50;
    ld(1, 53, 53, 0, 0, 0, 0);
    cyc();
    check("hit_on", int'(hit[1]), 1);
    ld(1, 54, 50, 0, 0, 0, 0);
    cyc();
    check("hit_edge", int'(hit[1]), 0);
    ld(1, 53, 53, 0, 0, 0, 0);
    cyc();
    check("hit_on2", int'(hit[1]), 1);
    kill = 3'b010;
    cyc();
    kill = 0;
    cyc();
    check("hit_kill", int'(hit[1]), 0);
    for (int k = 0; k < 600; k++) begin
      resetn = ($urandom_range(0, 99) != 0);
      play = ($urandom_range(0, 4) != 0);
      load_valid = ($urandom_range(0, 4) == 0);
      load_id = 2'($urandom_range(0, 3));
      load_x = 8'($urandom_range(0, 255));
      load_y = 7'($urandom_range(0, 127));
      load_dx = 3'($urandom_range(0, 7));
      load_dy = 3'($urandom_range(0, 7));
      load_left = 1'($urandom_range(0, 1));
      load_up = 1'($urandom_range(0, 1));
      kill = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 7) == 0) begin
        player_x = 8'($urandom_range(0, 159));
        player_y = 7'($urandom_range(0, 119));
      end
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
